// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 device-to-host receiver feeding a small byte FIFO.
// Synchronises the raw PS/2 pins, deserialises 11-bit frames (start, 8 data
// bits LSB-first, odd parity, stop), validates each frame and queues the
// good bytes for the keyboard state logic.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   nextdata_n  in   active-low pop request, sampled on clk
//   data        out  FIFO head byte, 8'h00 when empty (combinational)
//   ready       out  FIFO non-empty
//   overflow    out  sticky: valid frame dropped because FIFO was full
//   frame_err   out  sticky: frame dropped for bad start/stop/parity
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned PTR_W       = 3,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BUF_W  = 10;
    localparam int unsigned TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    // ------------------------------------------------------------------
    // Pin synchronisers; idle bus level is high on both lines
    // ------------------------------------------------------------------
    logic [2:0] ps2c_sync;
    logic [1:0] ps2d_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps2c_sync <= 3'b111;
            ps2d_sync <= 2'b11;
        end else begin
            ps2c_sync <= {ps2c_sync[1:0], ps2_clk};
            ps2d_sync <= {ps2d_sync[0], ps2_data};
        end
    end

    logic ps2_fall;
    logic ps2_bit;

    assign ps2_fall = (ps2c_sync[2:1] == 2'b10);
    assign ps2_bit  = ps2d_sync[1];

    // ------------------------------------------------------------------
    // Frame receiver FSM: state register
    // ------------------------------------------------------------------
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [BUF_W-1:0] shift_buf;
    logic [BUF_W-1:0] shift_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_nxt;
    logic             frame_done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_buf <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_buf <= shift_nxt;
            to_cnt    <= to_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver FSM: next state. Bits enter at the MSB so that after
    // ten shifts buf[0]=start, buf[8:1]=data, buf[9]=parity; the stop bit
    // is judged live on the 11th fall and never stored.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_buf;
        to_cnt_nxt   = '0;
        frame_done_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ps2_fall) begin
                    state_nxt   = ST_RECV;
                    shift_nxt   = {ps2_bit, shift_buf[BUF_W-1:1]};
                    bit_cnt_nxt = CNT_W'(1);
                end
            end
            ST_RECV: begin
                if (ps2_fall) begin
                    if (bit_cnt == CNT_W'(10)) begin
                        state_nxt    = ST_IDLE;
                        bit_cnt_nxt  = '0;
                        frame_done_c = 1'b1;
                    end else begin
                        shift_nxt   = {ps2_bit, shift_buf[BUF_W-1:1]};
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    // Stalled frame: abandon silently, no error flag
                    state_nxt   = ST_IDLE;
                    bit_cnt_nxt = '0;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    // Start low, stop high, odd parity across data and parity bit
    logic frame_ok_c;

    assign frame_ok_c = ~shift_buf[0] & ps2_bit & (^shift_buf[9:1]);

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [OCC_W-1:0] occ;
    logic             full_c;
    logic             push_c;
    logic             pop_c;

    assign full_c = (occ == OCC_W'(FIFO_DEPTH));
    assign ready  = (occ != '0);
    assign pop_c  = ready & ~nextdata_n;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_c = frame_done_c & frame_ok_c & (~full_c | pop_c);

    // Storage is not reset; reads are masked by ready while empty
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[w_ptr] <= shift_buf[8:1];
        end
    end

    // Pointers, occupancy and sticky status
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_c) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                occ <= occ + OCC_W'(1);
            end else if (pop_c && !push_c) begin
                occ <= occ - OCC_W'(1);
            end

            if (pop_c) begin
                overflow <= 1'b0;
            end else if (frame_done_c && frame_ok_c && full_c) begin
                overflow <= 1'b1;
            end

            if (frame_done_c && !frame_ok_c) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign data = ready ? fifo_mem[r_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
// Directed bench for ps2_rx_fifo: drives PS/2 frames bit by bit, pops the
// FIFO and checks outputs against hand-computed values. The PS/2 clock and
// timeout are scaled down so the whole run stays short.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

    localparam int unsigned TIMEOUT   = 300;
    localparam int unsigned HALF_BIT  = 20;   // clk cycles per PS/2 clock half-period

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int checks;
    int failures;

    ps2_rx_fifo #(
        .FIFO_DEPTH (8),
        .PTR_W      (3),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cyc(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits of a frame; bad_par inverts the parity bit
    task automatic send_bits(input logic [7:0] d, input logic bad_par, input int unsigned nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(HALF_BIT);
            ps2_clk = 1'b0;
            wait_cyc(HALF_BIT);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF_BIT);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_bits(d, 1'b0, 11);
    endtask

    task automatic pop;
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        do_reset();

        // Reset state
        check("rst_data", 32'(data), 32'h00);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // 1: single frame, single pop
        send_frame(8'h1C);
        check("t1_ready", 32'(ready), 32'h1);
        check("t1_data", 32'(data), 32'h1C);
        pop();
        check("t1_pop_ready", 32'(ready), 32'h0);
        check("t1_pop_data", 32'(data), 32'h00);

        // 2: two frames in order
        send_frame(8'hF0);
        send_frame(8'h1C);
        check("t2_head", 32'(data), 32'hF0);
        pop();
        check("t2_second", 32'(data), 32'h1C);
        pop();
        check("t2_empty", 32'(ready), 32'h0);

        // 3: nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i));
        check("t3_overflow", 32'(overflow), 32'h1);
        check("t3_head", 32'(data), 32'h01);
        check("t3_frame_err", 32'(frame_err), 32'h0);
        pop();
        check("t3_pop_overflow", 32'(overflow), 32'h0);
        check("t3_pop_data", 32'(data), 32'h02);
        for (int i = 0; i < 6; i++) pop();
        check("t3_last", 32'(data), 32'h08);
        pop();
        check("t3_empty", 32'(ready), 32'h0);

        // 4: bad parity then good frame
        send_bits(8'h1C, 1'b1, 11);
        check("t4_bad_ready", 32'(ready), 32'h0);
        check("t4_frame_err", 32'(frame_err), 32'h1);
        send_frame(8'h29);
        check("t4_good_data", 32'(data), 32'h29);
        check("t4_err_sticky", 32'(frame_err), 32'h1);
        pop();

        // 5: stalled partial frame then full frame
        do_reset();
        check("t5_rst_err", 32'(frame_err), 32'h0);
        send_bits(8'h55, 1'b0, 5);
        wait_cyc(TIMEOUT + 50);
        check("t5_timeout_ready", 32'(ready), 32'h0);
        send_frame(8'h29);
        check("t5_data", 32'(data), 32'h29);
        check("t5_frame_err", 32'(frame_err), 32'h0);
        pop();
        check("t5_empty", 32'(ready), 32'h0);

        // 6: reset mid-frame drops queue and partial frame
        send_frame(8'h11);
        send_frame(8'h22);
        check("t6_queued", 32'(data), 32'h11);
        send_bits(8'h33, 1'b0, 5);
        do_reset();
        check("t6_rst_ready", 32'(ready), 32'h0);
        check("t6_rst_overflow", 32'(overflow), 32'h0);
        check("t6_rst_data", 32'(data), 32'h00);
        send_frame(8'h5A);
        check("t6_data", 32'(data), 32'h5A);
        pop();
        check("t6_single", 32'(ready), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
